tage_update_sched: RTL and testbench

//  Schedules branch-resolution updates into the TAGE predictor's single update port.

---
 rtl/tage_update_sched.sv | 133 +++++++++++++
 tb/tb_tage_update_sched.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tage_update_sched.sv
// In-order update scheduler for the TAGE predictor's single update port.
// Commit requests are compacted into a circular FIFO; one update is issued per cycle, overflow is dropped and counted.
module tage_update_sched #(
    parameter int NUM_REQ  = 2,
    parameter int DEPTH    = 8,
    parameter int PLEN     = 32,
    parameter int GHR_BITS = 8,
    parameter int DROP_W   = 16
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               flush_i,
    input  logic                               enable_i,
    input  logic [NUM_REQ-1:0]                 req_valid_i,
    input  logic [NUM_REQ-1:0][PLEN-1:0]       req_pc_i,
    input  logic [NUM_REQ-1:0][GHR_BITS-1:0]   req_ghr_i,
    input  logic [NUM_REQ-1:0]                 req_taken_i,
    output logic                               upd_valid_o,
    output logic [PLEN-1:0]                    upd_pc_o,
    output logic [GHR_BITS-1:0]                upd_ghr_o,
    output logic                               upd_taken_o,
    output logic [$clog2(DEPTH):0]             occupancy_o,
    output logic [DROP_W-1:0]                  drop_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int SUM_W = OCC_W + 1;
    localparam int DC_W  = ((DROP_W > SUM_W) ? DROP_W : SUM_W) + 1;
    localparam logic [OCC_W-1:0]  DEPTH_C  = OCC_W'(DEPTH);
    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

    logic [PTR_W-1:0]                 head_q, head_d;
    logic [PTR_W-1:0]                 tail_q, tail_d;
    logic [OCC_W-1:0]                 occ_q, occ_d;
    logic [DROP_W-1:0]                drop_q, drop_d;
    logic [DEPTH-1:0][PLEN-1:0]       mem_pc_q, mem_pc_d;
    logic [DEPTH-1:0][GHR_BITS-1:0]   mem_ghr_q, mem_ghr_d;
    logic [DEPTH-1:0]                 mem_taken_q, mem_taken_d;

    logic                             pop_s;
    logic [SUM_W-1:0]                 free_s;
    logic [SUM_W-1:0]                 acc_s;
    logic [SUM_W-1:0]                 drop_s;
    logic [PTR_W-1:0]                 wptr_s;
    logic [DC_W-1:0]                  drop_sum_s;

    // Issue path: head entry is presented whenever the queue is non-empty, enabled and not flushing
    always_comb begin
        pop_s = enable_i && !flush_i && (occ_q != '0);
        if (pop_s) begin
            upd_pc_o    = mem_pc_q[head_q];
            upd_ghr_o   = mem_ghr_q[head_q];
            upd_taken_o = mem_taken_q[head_q];
        end else begin
            upd_pc_o    = '0;
            upd_ghr_o   = '0;
            upd_taken_o = 1'b0;
        end
        upd_valid_o = pop_s;
    end

    // Enqueue: compact valid ports in port order; a same-cycle pop frees one slot
    always_comb begin
        free_s      = SUM_W'(DEPTH_C) - SUM_W'(occ_q) + SUM_W'(pop_s);
        acc_s       = '0;
        drop_s      = '0;
        wptr_s      = tail_q;
        mem_pc_d    = mem_pc_q;
        mem_ghr_d   = mem_ghr_q;
        mem_taken_d = mem_taken_q;
        for (int p = 0; p < NUM_REQ; p++) begin
            if (req_valid_i[p] && !flush_i) begin
                if (acc_s < free_s) begin
                    wptr_s              = tail_q + acc_s[PTR_W-1:0];
                    mem_pc_d[wptr_s]    = req_pc_i[p];
                    mem_ghr_d[wptr_s]   = req_ghr_i[p];
                    mem_taken_d[wptr_s] = req_taken_i[p];
                    acc_s               = acc_s + SUM_W'(1);
                end else begin
                    drop_s = drop_s + SUM_W'(1);
                end
            end else begin
                drop_s = drop_s;
            end
        end
    end

    // Pointer, occupancy and saturating drop-counter next state
    always_comb begin
        drop_sum_s = DC_W'(drop_q) + DC_W'(drop_s);
        if (drop_sum_s > DC_W'(DROP_MAX)) begin
            drop_d = DROP_MAX;
        end else begin
            drop_d = drop_sum_s[DROP_W-1:0];
        end
        if (flush_i) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
        end else begin
            head_d = head_q + PTR_W'(pop_s);
            tail_d = tail_q + acc_s[PTR_W-1:0];
            occ_d  = occ_q + acc_s[OCC_W-1:0] - OCC_W'(pop_s);
        end
    end

    // Control state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
            drop_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
            drop_q <= drop_d;
        end
    end

    // Payload storage; contents are never observed while the queue is empty, so no reset
    always_ff @(posedge clk_i) begin
        mem_pc_q    <= mem_pc_d;
        mem_ghr_q   <= mem_ghr_d;
        mem_taken_q <= mem_taken_d;
    end

    assign occupancy_o = occ_q;
    assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_tage_update_sched.sv
// Directed bench for tage_update_sched: stimulus pushes expected updates into a scoreboard queue,
// a negedge monitor pops and compares whenever the scheduler issues.
module tb_tage_update_sched;

    typedef struct packed {
        logic [31:0] pc;
        logic [7:0]  ghr;
        logic        taken;
    } ent_t;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             flush_i = 1'b0;
    logic             enable_i = 1'b0;
    logic [1:0]       req_valid_i = '0;
    logic [1:0][31:0] req_pc_i = '0;
    logic [1:0][7:0]  req_ghr_i = '0;
    logic [1:0]       req_taken_i = '0;

    logic        upd_valid_a, upd_taken_a, upd_valid_b, upd_taken_b;
    logic [31:0] upd_pc_a, upd_pc_b;
    logic [7:0]  upd_ghr_a, upd_ghr_b;
    logic [3:0]  occ_a, occ_b;
    logic [15:0] drop_a;
    logic [1:0]  drop_b;

    int   n_chk = 0;
    int   n_fail = 0;
    ent_t exp_q[$];
    ent_t mon_e;

    tage_update_sched u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .enable_i(enable_i),
        .req_valid_i(req_valid_i), .req_pc_i(req_pc_i), .req_ghr_i(req_ghr_i),
        .req_taken_i(req_taken_i), .upd_valid_o(upd_valid_a), .upd_pc_o(upd_pc_a),
        .upd_ghr_o(upd_ghr_a), .upd_taken_o(upd_taken_a), .occupancy_o(occ_a),
        .drop_cnt_o(drop_a)
    );

    tage_update_sched #(.DROP_W(2)) u_dut_sat (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .enable_i(enable_i),
        .req_valid_i(req_valid_i), .req_pc_i(req_pc_i), .req_ghr_i(req_ghr_i),
        .req_taken_i(req_taken_i), .upd_valid_o(upd_valid_b), .upd_pc_o(upd_pc_b),
        .upd_ghr_o(upd_ghr_b), .upd_taken_o(upd_taken_b), .occupancy_o(occ_b),
        .drop_cnt_o(drop_b)
    );

    always #5 clk_i = ~clk_i;

    function automatic ent_t ent_of(input int id);
        ent_t e;
        if (id == 0) begin
            e.pc    = 32'h8000_0010;
            e.ghr   = 8'hA5;
            e.taken = 1'b1;
        end else begin
            e.pc    = 32'h1000_0000 + 32'(id) * 32'd16;
            e.ghr   = 8'(id) ^ 8'h3C;
            e.taken = id[0];
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of requests; accN says whether that request is expected to be queued
    task automatic drive(input bit v0, input int id0, input bit v1, input int id1,
                         input bit acc0, input bit acc1);
        ent_t e0, e1;
        e0 = ent_of(id0);
        e1 = ent_of(id1);
        req_valid_i    = {v1, v0};
        req_pc_i[0]    = e0.pc;
        req_ghr_i[0]   = e0.ghr;
        req_taken_i[0] = e0.taken;
        req_pc_i[1]    = e1.pc;
        req_ghr_i[1]   = e1.ghr;
        req_taken_i[1] = e1.taken;
        if (acc0) exp_q.push_back(e0);
        if (acc1) exp_q.push_back(e1);
        @(posedge clk_i);
        #1;
        req_valid_i = '0;
    endtask

    task automatic wait_drain(input string name, input int max_cyc);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < max_cyc) begin
            @(posedge clk_i);
            #1;
            k++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    // Scoreboard monitor: every issued update must match the oldest expected entry
    always @(negedge clk_i) begin
        if (rst_ni && upd_valid_a) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_issue: got pc 0x%0h, required no issue (t=%0t)", upd_pc_a, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("issue_pc", upd_pc_a, mon_e.pc);
                chk("issue_ghr", 32'(upd_ghr_a), 32'(mon_e.ghr));
                chk("issue_taken", 32'(upd_taken_a), 32'(mon_e.taken));
                chk("issue_sat_valid", 32'(upd_valid_b), 32'd1);
                chk("issue_sat_pc", upd_pc_b, mon_e.pc);
                chk("issue_sat_ghr", 32'(upd_ghr_b), 32'(mon_e.ghr));
                chk("issue_sat_taken", 32'(upd_taken_b), 32'(mon_e.taken));
            end
        end
    end

    initial begin
        enable_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_occ", 32'(occ_a), 32'd0);
        chk("rst_valid", 32'(upd_valid_a), 32'd0);
        chk("rst_pc", upd_pc_a, 32'd0);
        chk("rst_drop", 32'(drop_a), 32'd0);
        rst_ni = 1'b1;

        // Single request, one-cycle latency
        drive(1'b1, 0, 1'b0, 0, 1'b1, 1'b0);
        chk("t1_occ1", 32'(occ_a), 32'd1);
        chk("t1_valid1", 32'(upd_valid_a), 32'd1);
        @(posedge clk_i);
        #1;
        chk("t1_valid2", 32'(upd_valid_a), 32'd0);
        chk("t1_occ2", 32'(occ_a), 32'd0);

        // Two ports: port 0 issued first
        drive(1'b1, 1, 1'b1, 2, 1'b1, 1'b1);
        chk("t2_occ", 32'(occ_a), 32'd2);
        wait_drain("t2_drain", 4);
        chk("t2_occ_end", 32'(occ_a), 32'd0);

        // Fill while disabled, fifth cycle overflows
        enable_i = 1'b0;
        for (int i = 0; i < 4; i++) drive(1'b1, 10 + 2 * i, 1'b1, 11 + 2 * i, 1'b1, 1'b1);
        drive(1'b1, 18, 1'b1, 19, 1'b0, 1'b0);
        chk("t3_occ", 32'(occ_a), 32'd8);
        chk("t3_drop", 32'(drop_a), 32'd2);
        chk("t3_drop_sat", 32'(drop_b), 32'd2);
        chk("t3_no_issue", 32'(upd_valid_a), 32'd0);
        enable_i = 1'b1;
        wait_drain("t3_drain", 8);
        chk("t3_occ_end", 32'(occ_a), 32'd0);

        // Full and enabled: popped slot reused by port 0, port 1 dropped
        enable_i = 1'b0;
        for (int i = 0; i < 4; i++) drive(1'b1, 20 + 2 * i, 1'b1, 21 + 2 * i, 1'b1, 1'b1);
        chk("t4_full", 32'(occ_a), 32'd8);
        enable_i = 1'b1;
        drive(1'b1, 28, 1'b1, 29, 1'b1, 1'b0);
        chk("t4_occ", 32'(occ_a), 32'd8);
        chk("t4_drop", 32'(drop_a), 32'd3);
        chk("t4_drop_sat", 32'(drop_b), 32'd3);
        wait_drain("t4_drain", 12);
        chk("t4_occ_end", 32'(occ_a), 32'd0);

        // Flush with occupancy 5 and both ports valid
        enable_i = 1'b0;
        drive(1'b1, 30, 1'b1, 31, 1'b0, 1'b0);
        drive(1'b1, 32, 1'b1, 33, 1'b0, 1'b0);
        drive(1'b1, 34, 1'b0, 0, 1'b0, 1'b0);
        chk("t5_occ5", 32'(occ_a), 32'd5);
        enable_i    = 1'b1;
        flush_i     = 1'b1;
        req_valid_i = 2'b11;
        #1;
        chk("t5_flush_valid", 32'(upd_valid_a), 32'd0);
        @(posedge clk_i);
        #1;
        flush_i     = 1'b0;
        req_valid_i = '0;
        chk("t5_occ", 32'(occ_a), 32'd0);
        chk("t5_valid", 32'(upd_valid_a), 32'd0);
        chk("t5_drop", 32'(drop_a), 32'd3);
        drive(1'b1, 40, 1'b0, 0, 1'b1, 1'b0);
        chk("t5_after_occ", 32'(occ_a), 32'd1);
        wait_drain("t5_drain", 4);

        // Only port 1 valid
        drive(1'b0, 0, 1'b1, 41, 1'b0, 1'b1);
        chk("t6_p1_occ", 32'(occ_a), 32'd1);
        wait_drain("t6_p1_drain", 4);
        chk("t6_p1_occ_end", 32'(occ_a), 32'd0);

        // Clear drop counters, then five drops: narrow counter sticks at 3
        rst_ni = 1'b0;
        #1;
        chk("t6_rst_drop", 32'(drop_a), 32'd0);
        chk("t6_rst_drop_sat", 32'(drop_b), 32'd0);
        @(posedge clk_i);
        #1;
        rst_ni   = 1'b1;
        enable_i = 1'b0;
        for (int i = 0; i < 4; i++) drive(1'b1, 50 + 2 * i, 1'b1, 51 + 2 * i, 1'b1, 1'b1);
        drive(1'b1, 58, 1'b1, 59, 1'b0, 1'b0);
        drive(1'b1, 60, 1'b1, 61, 1'b0, 1'b0);
        drive(1'b1, 62, 1'b0, 0, 1'b0, 1'b0);
        chk("t6_drop5", 32'(drop_a), 32'd5);
        chk("t6_drop_sat", 32'(drop_b), 32'd3);
        chk("t6_occ_full", 32'(occ_b), 32'd8);

        // Asynchronous reset mid-burst
        req_valid_i = 2'b11;
        enable_i    = 1'b1;
        #1;
        chk("t6_pre_valid", 32'(upd_valid_a), 32'd1);
        chk("t6_pre_pc", upd_pc_a, ent_of(50).pc);
        rst_ni = 1'b0;
        #1;
        chk("t6_async_valid", 32'(upd_valid_a), 32'd0);
        chk("t6_async_pc", upd_pc_a, 32'd0);
        chk("t6_async_ghr", 32'(upd_ghr_a), 32'd0);
        chk("t6_async_taken", 32'(upd_taken_a), 32'd0);
        chk("t6_async_occ", 32'(occ_a), 32'd0);
        chk("t6_async_drop", 32'(drop_a), 32'd0);
        chk("t6_async_drop_sat", 32'(drop_b), 32'd0);
        exp_q.delete();
        @(posedge clk_i);
        #1;
        req_valid_i = '0;
        rst_ni      = 1'b1;
        drive(1'b1, 70, 1'b0, 0, 1'b1, 1'b0);
        chk("t6_post_occ", 32'(occ_a), 32'd1);
        wait_drain("t6_post_drain", 4);
        chk("t6_post_occ_end", 32'(occ_a), 32'd0);

        repeat (2) @(posedge clk_i);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
